// File: rtl/debug_pkg.sv
// Shared debug-unit definitions: frame header default, serializer state
// encoding and the byte-count helper used to size the snapshot.
package debug_pkg;

  localparam logic [7:0] FRAME_HEADER_DEF = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int num_bytes(input int total_bits);
    return (total_bits + 7) / 8;
  endfunction

endpackage

// File: rtl/pipeline_snapshot_serializer.sv
// Captures the four pipeline latches on request and streams them to the UART TX
// as header + data bytes (+ XOR checksum when SNAPSHOT_CHECKSUM_EN is defined).
module pipeline_snapshot_serializer
  import debug_pkg::*;
#(
  parameter int         IF_ID_SIZE   = 42,
  parameter int         ID_EX_SIZE   = 148,
  parameter int         EX_MEM_SIZE  = 80,
  parameter int         MEM_WB_SIZE  = 46,
  parameter logic [7:0] FRAME_HEADER = FRAME_HEADER_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [IF_ID_SIZE-1:0]  i_IF_ID_content,
  input  logic [ID_EX_SIZE-1:0]  i_ID_EX_content,
  input  logic [EX_MEM_SIZE-1:0] i_EX_MEM_content,
  input  logic [MEM_WB_SIZE-1:0] i_MEM_WB_content,
  input  logic                   i_tx_done,
  output logic [7:0]             o_tx_byte,
  output logic                   o_tx_start,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int TOTAL_BITS = IF_ID_SIZE + ID_EX_SIZE + EX_MEM_SIZE + MEM_WB_SIZE;
  localparam int NUM_BYTES  = num_bytes(TOTAL_BITS);
  localparam int SNAP_W     = (NUM_BYTES + 1) * 8;
  localparam int IDX_W      = $clog2(NUM_BYTES + 2);
`ifdef SNAPSHOT_CHECKSUM_EN
  localparam int FRAME_LEN  = NUM_BYTES + 2;
`else
  localparam int FRAME_LEN  = NUM_BYTES + 1;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_idx;
  logic [SNAP_W-1:0] r_snap;
  logic [7:0]        r_tx_byte;
  logic              r_tx_start;
  logic              w_capture_en;
  logic              w_accept;
  logic [7:0]        w_byte;
  logic [SNAP_W-1:0] w_capture;

  assign w_capture_en = (r_state == ST_IDLE) && i_start;
  // A done pulse in the same cycle as our start pulse belongs to no byte yet.
  assign w_accept     = (r_state == ST_WAIT) && i_tx_done && !r_tx_start;

  // Header rides in the low byte so every frame byte comes from r_snap[7:0].
  assign w_capture = SNAP_W'({i_MEM_WB_content, i_EX_MEM_content,
                              i_ID_EX_content, i_IF_ID_content, FRAME_HEADER});

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_next = ST_SEND;
      ST_SEND: w_next = ST_WAIT;
      ST_WAIT: if (w_accept) w_next = (r_idx == LAST_IDX) ? ST_DONE : ST_SEND;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    if (r_state != ST_IDLE) o_busy = 1'b1;
    if (r_state == ST_DONE) o_done = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_idx      <= '0;
      r_tx_start <= 1'b0;
      r_tx_byte  <= 8'h00;
    end else begin
      r_tx_start <= (r_state == ST_SEND);
      if (w_capture_en)
        r_idx <= '0;
      else if (w_accept && (r_idx != LAST_IDX))
        r_idx <= r_idx + IDX_W'(1);
      if (r_state == ST_SEND)
        r_tx_byte <= w_byte;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_capture_en)
      r_snap <= w_capture;
    else if (w_accept)
      r_snap <= {8'h00, r_snap[SNAP_W-1:8]};
  end

`ifdef SNAPSHOT_CHECKSUM_EN
  localparam logic [IDX_W-1:0] CSUM_IDX = IDX_W'(NUM_BYTES + 1);
  logic [7:0] r_csum;

  // Fold only data bytes: the header (index 0) and the checksum itself are excluded.
  always_ff @(posedge i_clk) begin
    if (w_capture_en)
      r_csum <= 8'h00;
    else if (w_accept && (r_idx != '0) && (r_idx != CSUM_IDX))
      r_csum <= r_csum ^ r_tx_byte;
  end

  assign w_byte = (r_idx == CSUM_IDX) ? r_csum : r_snap[7:0];
`else
  assign w_byte = r_snap[7:0];
`endif

  assign o_tx_byte  = r_tx_byte;
  assign o_tx_start = r_tx_start;

endmodule

// File: tb/tb_pipeline_snapshot_serializer.sv
// Directed + randomized bench for pipeline_snapshot_serializer with a TX responder
// and a frame model built from the snapshot layout rules.
module tb_pipeline_snapshot_serializer;

  localparam int IFW = 42, IDW = 148, EXW = 80, MWW = 46;
  localparam int TOT = IFW + IDW + EXW + MWW;
  localparam int NB  = (TOT + 7) / 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [IFW-1:0] if_id = '0;
  logic [IDW-1:0] id_ex = '0;
  logic [EXW-1:0] ex_mem = '0;
  logic [MWW-1:0] mem_wb = '0;
  logic           tx_done = 1'b0;
  logic [7:0]     tx_byte;
  logic           tx_start;
  logic           busy;
  logic           done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int rsp_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  pipeline_snapshot_serializer dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start),
    .i_IF_ID_content(if_id), .i_ID_EX_content(id_ex),
    .i_EX_MEM_content(ex_mem), .i_MEM_WB_content(mem_wb),
    .i_tx_done(tx_done), .o_tx_byte(tx_byte), .o_tx_start(tx_start),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  // TX core model: accept a byte on o_tx_start, report done 3 cycles later.
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (!rst_n) begin
      rsp_cnt = 0;
    end else begin
      if (rsp_cnt > 0) begin
        rsp_cnt = rsp_cnt - 1;
        if (rsp_cnt == 0) tx_done = 1'b1;
      end
      if (tx_start) begin
        rx_q.push_back(tx_byte);
        rsp_cnt = 3;
      end
      if (done) done_cnt = done_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_expected();
    logic [NB*8-1:0] snap;
    logic [7:0] cs;
    snap = '0;
    snap[IFW-1:0] = if_id;
    snap[IFW+IDW-1:IFW] = id_ex;
    snap[IFW+IDW+EXW-1:IFW+IDW] = ex_mem;
    snap[TOT-1:IFW+IDW+EXW] = mem_wb;
    cs = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int k = 0; k < NB; k++) begin
      exp_q.push_back(snap[8*k +: 8]);
      cs = cs ^ snap[8*k +: 8];
    end
`ifdef SNAPSHOT_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  task automatic randomize_latches();
    logic [159:0] r;
    for (int i = 0; i < 5; i++) r[32*i +: 32] = $urandom;
    if_id = r[IFW-1:0];
    for (int i = 0; i < 5; i++) r[32*i +: 32] = $urandom;
    id_ex = r[IDW-1:0];
    for (int i = 0; i < 5; i++) r[32*i +: 32] = $urandom;
    ex_mem = r[EXW-1:0];
    for (int i = 0; i < 5; i++) r[32*i +: 32] = $urandom;
    mem_wb = r[MWW-1:0];
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_frame(input string tag, input int d0);
    int n;
    n = 0;
    while (done_cnt <= d0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt <= d0) chk({tag, "_timeout"}, 64'(done_cnt), 64'(d0 + 1));
  endtask

  task automatic compare_frame(input string tag);
    int n;
    chk({tag, "_len"}, 64'(rx_q.size()), 64'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_byte%0d", tag, i), 64'(rx_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    int d0;
    int n;
    int any_active;

    // Reset and idle behaviour
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_byte", 64'(tx_byte), 64'd0);
    rst_n = 1'b1;
    any_active = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_start || busy || done || tx_byte != 8'h00) any_active++;
    end
    chk("idle_quiet", 64'(any_active), 64'd0);

    // Frame 1: IF_ID = 1, with header latency check
    if_id = 42'h1;
    build_expected();
    rx_q.delete();
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("lat_busy_n1", 64'(busy), 64'd1);
    chk("lat_start_n1", 64'(tx_start), 64'd0);
    @(negedge clk);
    chk("lat_start_n2", 64'(tx_start), 64'd1);
    chk("lat_hdr_n2", 64'(tx_byte), 64'hA5);
    wait_frame("f1", d0);
    @(negedge clk);
    chk("f1_busy_after", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
    chk("f1_done_cnt", 64'(done_cnt), 64'(d0 + 1));
    compare_frame("f1");

    // Frame 2: all ones
    if_id = '1; id_ex = '1; ex_mem = '1; mem_wb = '1;
    build_expected();
    rx_q.delete();
    d0 = done_cnt;
    pulse_start();
    wait_frame("f2", d0);
    repeat (5) @(negedge clk);
    compare_frame("f2");
    if (rx_q.size() > NB) chk("f2_last_data", 64'(rx_q[NB]), 64'h0F);
    else chk("f2_last_data_len", 64'(rx_q.size()), 64'(NB + 1));
`ifdef SNAPSHOT_CHECKSUM_EN
    if (rx_q.size() > NB + 1) chk("f2_csum", 64'(rx_q[NB+1]), 64'hF0);
    else chk("f2_csum_len", 64'(rx_q.size()), 64'(NB + 2));
`endif

    // Frame 3: random data, mid-frame restart request and latch changes
    randomize_latches();
    build_expected();
    rx_q.delete();
    d0 = done_cnt;
    pulse_start();
    n = 0;
    while (rx_q.size() < 6 && n < 500) begin @(negedge clk); n++; end
    chk("f3_progress", 64'(rx_q.size() >= 6), 64'd1);
    pulse_start();
    randomize_latches();
    wait_frame("f3", d0);
    repeat (60) @(negedge clk);
    chk("f3_single_done", 64'(done_cnt), 64'(d0 + 1));
    compare_frame("f3");

    // Frame 4: reset after the 5th byte aborts the frame
    randomize_latches();
    rx_q.delete();
    d0 = done_cnt;
    pulse_start();
    n = 0;
    while (rx_q.size() < 5 && n < 500) begin @(negedge clk); n++; end
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_start", 64'(tx_start), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_byte", 64'(tx_byte), 64'd0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(d0));
    chk("abort_no_more_bytes", 64'(rx_q.size()), 64'd5);

    // Frame 5: fresh frame after the abort
    randomize_latches();
    build_expected();
    rx_q.delete();
    d0 = done_cnt;
    pulse_start();
    wait_frame("f5", d0);
    repeat (5) @(negedge clk);
    compare_frame("f5");

    // Frames 6+7: back-to-back, second start in first cycle with busy low
    randomize_latches();
    build_expected();
    rx_q.delete();
    d0 = done_cnt;
    pulse_start();
    n = 0;
    while (!done && n < 2000) begin @(negedge clk); n++; end
    chk("b2b_done_seen", 64'(done), 64'd1);
    @(negedge clk);
    chk("b2b_busy_low", 64'(busy), 64'd0);
    compare_frame("f6");
    randomize_latches();
    build_expected();
    rx_q.delete();
    pulse_start();
    wait_frame("f7", d0 + 1);
    repeat (5) @(negedge clk);
    chk("b2b_done_total", 64'(done_cnt), 64'(d0 + 2));
    compare_frame("f7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
